// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: program words stream in over a valid/ready port,
// then the fetch stage reads them back with a registered one-cycle latency.
module instr_mem_loadable #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 4,
    parameter int                PC_W     = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    input  logic              fetch_en,
    input  logic [PC_W-1:0]   fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [1:0]        fetch_err,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   wptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                beat;
    logic                final_beat;
    logic                enter_load;
    logic [ADDR_W-1:0]   index;
    logic                misaligned;
    logic                unmapped;

    // Load handshake: a beat transfers on a cycle where load_valid && load_ready.
    // load_ready is a pure decode of the state register, so it never depends on
    // load_valid and changes only on clock edges.
    assign load_ready = (state == LOAD);
    assign busy       = (state == LOAD);
    assign dbg_state  = state;

    assign beat       = load_valid && load_ready;
    assign final_beat = load_last || (&wptr);
    assign enter_load = (state != LOAD) && (state_next == LOAD);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_start) state_next = LOAD;
            LOAD:    if (beat && final_beat) state_next = RUN;
            RUN:     if (load_start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wptr       <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
        end else begin
            state     <= state_next;
            load_done <= beat && final_beat;
            if (enter_load) begin
                wptr       <= '0;
                word_count <= '0;
            end else if (beat) begin
                wptr <= wptr + 1'b1;
                if (final_beat) word_count <= {1'b0, wptr} + 1'b1;
            end
        end
    end

    // Array storage has no reset; word_count gates every read so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
        if (beat) mem[wptr] <= load_data;
    end

    assign index      = fetch_addr[ADDR_W+1:2];
    assign misaligned = (fetch_addr[1:0] != 2'b00);
    assign unmapped   = (state != RUN)
                     || ((fetch_addr >> (ADDR_W + 2)) != '0)
                     || ({1'b0, index} >= word_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            instr       <= NOP_WORD;
            fetch_err   <= 2'b00;
        end else begin
            instr_valid <= fetch_en;
            if (fetch_en) begin
                fetch_err <= {unmapped, misaligned};
                instr     <= (unmapped || misaligned) ? NOP_WORD : mem[index];
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: scenario tasks drive loads and fetches; fetch
// results are predicted from a reference program image and checked in order.
module tb_instr_mem_loadable;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 4;
    localparam int          PC_W   = 32;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   word_count;
    logic              fetch_en = 1'b0;
    logic [PC_W-1:0]   fetch_addr = '0;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [1:0]        fetch_err;
    logic              busy;
    logic [1:0]        dbg_state;

    instr_mem_loadable #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .word_count(word_count), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .instr(instr), .instr_valid(instr_valid), .fetch_err(fetch_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    // Scoreboard entries are {fetch_err, instr}.
    logic [DATA_W+1:0] exp_q[$];

    // Reference program image.
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                model_count = 0;
    int                model_wp = 0;
    bit                model_run = 1'b0;
    logic [DATA_W-1:0] load_buf [DEPTH];

    function automatic logic [DATA_W+1:0] model_fetch(input logic [PC_W-1:0] a);
        logic [ADDR_W-1:0] idx;
        logic              mis;
        logic              unm;
        idx = a[ADDR_W+1:2];
        mis = (a[1:0] != 2'b00);
        unm = !model_run || (a[PC_W-1:ADDR_W+2] != 0) || (int'(idx) >= model_count);
        return {unm, mis, (unm || mis) ? NOP : model_mem[idx]};
    endfunction

    // Each fetch pushed at a negedge must come back right after the next posedge.
    always @(posedge clk) begin
        logic [DATA_W+1:0] e;
        #1;
        if (load_done) done_cnt++;
        if (exp_q.size() != 0 || instr_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_instr_valid: got instr_valid=%0b instr=%h, expected no response",
                         instr_valid, instr);
            end else begin
                e = exp_q.pop_front();
                if (instr_valid !== 1'b1 || {fetch_err, instr} !== e) begin
                    n_err++;
                    $display("FAIL fetch_result: got valid=%0b err=%b instr=%h, expected valid=1 err=%b instr=%h",
                             instr_valid, fetch_err, instr, e[DATA_W+1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic do_fetch(input logic [PC_W-1:0] a);
        @(negedge clk);
        fetch_en   = 1'b1;
        fetch_addr = a;
        exp_q.push_back(model_fetch(a));
    endtask

    task automatic fetch_stop();
        @(negedge clk);
        fetch_en = 1'b0;
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start  = 1'b0;
        model_run   = 1'b0;
        model_count = 0;
        model_wp    = 0;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input bit last, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            @(negedge clk);
            load_valid = 1'b0;
            load_data  = $urandom;
            load_last  = $urandom_range(1, 0);
        end
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        if (load_ready === 1'b1) begin
            model_mem[model_wp] = d;
            model_wp++;
            if (last || model_wp == DEPTH) begin
                model_count = model_wp;
                model_run   = 1'b1;
            end
        end
    endtask

    task automatic load_body(input int n, input bit use_last, input int max_gap);
        int done_before;
        done_before = done_cnt;
        n_vec++;
        if (load_ready !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL load_entry: got ready=%0b busy=%0b, expected 1 1", load_ready, busy);
        end
        for (int i = 0; i < n; i++) send_beat(load_buf[i], use_last && (i == n - 1), max_gap);
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        n_vec++;
        if (done_cnt - done_before != 1) begin
            n_err++;
            $display("FAIL load_done_pulse: got %0d pulses, expected 1", done_cnt - done_before);
        end
        n_vec++;
        if (word_count !== (ADDR_W+1)'(model_count) || load_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL load_end: got count=%0d ready=%0b busy=%0b, expected count=%0d ready=0 busy=0",
                     word_count, load_ready, busy, model_count);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_vec++;
        if ({load_ready, busy, instr_valid, load_done, fetch_err, word_count, instr} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, {(ADDR_W+1){1'b0}}, NOP}) begin
            n_err++;
            $display("FAIL %s: got ready=%0b busy=%0b ivalid=%0b done=%0b err=%b count=%0d instr=%h, expected all zero/NOP",
                     name, load_ready, busy, instr_valid, load_done, fetch_err, word_count, instr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        do_fetch(32'h0);
        fetch_stop();
        n_vec++;
        if (load_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_load_ready: got %0b, expected 0", load_ready);
        end
    endtask

    task automatic test_basic_load();
        load_buf[0] = 32'h2008_0005;
        load_buf[1] = 32'h2009_0003;
        load_buf[2] = 32'h0109_5020;
        start_load();
        load_body(3, 1'b1, 0);
        do_fetch(32'h0);
        do_fetch(32'h4);
        do_fetch(32'h8);
        do_fetch(32'hC);
        fetch_stop();
    endtask

    task automatic test_errors();
        do_fetch(32'h6);
        do_fetch(32'h40);
        do_fetch(32'h42);
        do_fetch(32'h8000_0000);
        fetch_stop();
        do_fetch(32'h4);
        fetch_stop();
    endtask

    task automatic test_full_load();
        int done_before;
        for (int i = 0; i < DEPTH; i++) load_buf[i] = $urandom;
        start_load();
        load_body(DEPTH, 1'b0, 0);
        done_before = done_cnt;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        n_vec++;
        if (load_ready !== 1'b0) begin
            n_err++;
            $display("FAIL beat_after_full: got load_ready=%0b, expected 0", load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0;
        n_vec++;
        if (word_count !== 5'd16 || done_cnt != done_before) begin
            n_err++;
            $display("FAIL full_count: got count=%0d extra_done=%0d, expected 16 and 0",
                     word_count, done_cnt - done_before);
        end
        for (int i = DEPTH - 1; i >= 0; i--) do_fetch(PC_W'(i * 4));
        fetch_stop();
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 5; i++) load_buf[i] = $urandom;
        start_load();
        load_body(5, 1'b1, 3);
        for (int i = 0; i < 6; i++) do_fetch(PC_W'(i * 4));
        fetch_stop();
    endtask

    task automatic test_fetch_with_start();
        // Same-edge fetch and load_start: old image answers, then LOAD blocks reads.
        @(negedge clk);
        fetch_en   = 1'b1;
        fetch_addr = 32'h4;
        load_start = 1'b1;
        exp_q.push_back(model_fetch(32'h4));
        @(negedge clk);
        load_start  = 1'b0;
        model_run   = 1'b0;
        model_count = 0;
        model_wp    = 0;
        fetch_addr  = 32'h0;
        exp_q.push_back(model_fetch(32'h0));
        fetch_stop();
        load_buf[0] = 32'h1111_0000;
        load_buf[1] = 32'h2222_0004;
        load_body(2, 1'b1, 1);
        do_fetch(32'h0);
        do_fetch(32'h4);
        do_fetch(32'h8);
        fetch_stop();
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 4; i++) load_buf[i] = $urandom;
        start_load();
        send_beat(load_buf[0], 1'b0, 0);
        send_beat(load_buf[1], 1'b0, 0);
        @(negedge clk);
        load_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_reset_outputs("reset_mid_load");
        model_run   = 1'b0;
        model_count = 0;
        model_wp    = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_fetch(32'h0);
        fetch_stop();
        start_load();
        load_body(4, 1'b1, 2);
        for (int i = 0; i < 4; i++) do_fetch(PC_W'(i * 4));
        fetch_stop();
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_errors();
        test_full_load();
        test_gaps();
        test_fetch_with_start();
        test_reset_mid_load();
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised instruction memory for the single-cycle MIPS core; successor to the fixed 16-word, init-only instruction store.
- Program words are streamed in over a valid/ready load port, then served to the fetch stage with registered 1-cycle read latency.
- Fetch addresses are byte addresses with alignment and range checking. Unmapped or illegal fetches return a NOP word and an error code.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 4, word-index width; DEPTH = 2^ADDR_W words.
- PC_W, 32, fetch byte-address width; must satisfy PC_W >= ADDR_W+2.
- NOP_WORD, 32'h0000_0000, word returned on any error or unserved fetch (MIPS sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  begin new program load; pulse.
- load_valid  in  1  load_data beat valid.
- load_data  in  DATA_W  program word.
- load_last  in  1  marks final word of the program; qualified by load_valid.
- load_ready  out  1  block accepts a load beat.
- load_done  out  1  one-cycle pulse when the load completes.
- word_count  out  ADDR_W+1  number of words in the loaded program.
- fetch_en  in  1  fetch request.
- fetch_addr  in  PC_W  byte address (PC).
- instr  out  DATA_W  fetched instruction, registered.
- instr_valid  out  1  instr valid; asserted exactly 1 cycle after fetch_en.
- fetch_err  out  2  bit0 = misaligned, bit1 = unmapped; valid with instr_valid.
- busy  out  1  high while in LOAD.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; word_count=0; write pointer=0.
  - load_ready=0, load_done=0, busy=0, instr_valid=0, instr=NOP_WORD, fetch_err=0.
  - Memory array is not cleared; it is unreadable until a load completes.
- FSM states IDLE, LOAD, RUN.
  - IDLE -> LOAD on load_start.
  - RUN -> LOAD on load_start.
  - LOAD -> RUN on the accepted final beat.
  - load_start while in LOAD is ignored.
- Entering LOAD: write pointer=0, word_count=0. load_ready=1 and busy=1 exactly while state=LOAD (registered from state).
- Load beat: load_valid && load_ready writes load_data to mem[wptr], then wptr increments.
  - Final beat is one with load_last=1, or the beat written at wptr=DEPTH-1 (array full); a load_last=0 beat at wptr=DEPTH-1 still terminates.
  - On the final beat: word_count=wptr+1 (range 1..DEPTH), load_done pulses next cycle, state=RUN.
  - Beats arriving after termination are not accepted (load_ready=0).
- Fetch, index = fetch_addr[ADDR_W+1:2]:
  - misaligned = fetch_addr[1:0] != 0.
  - unmapped = state != RUN, or any fetch_addr[PC_W-1:ADDR_W+2] != 0, or index >= word_count.
  - Cycle after fetch_en: instr_valid=1, fetch_err={unmapped,misaligned}. instr = mem[index] if both error bits are 0, else NOP_WORD.
  - fetch_en=0: instr_valid=0 next cycle; instr holds its last value.
  - Back-to-back fetches are supported at one per cycle.
- Fetch during LOAD: not served from the array; returns NOP_WORD with unmapped=1.
- Simultaneous fetch_en and load_start in RUN: the fetch is served from the old contents with the old word_count; LOAD is entered the same edge.
- Write and read to the same index in one cycle cannot occur, since fetches in LOAD are unmapped.
- Reset mid-load: the partial program is discarded (word_count=0); the next fetch is unmapped.

Test Plan:
- Reset, then fetch_en with addr 0x0 -> next cycle instr_valid=1, instr=0x00000000, fetch_err=2'b10; load_ready=0.
- load_start, then stream 3 words 0x20080005, 0x20090003, 0x01095020 with last on the third -> load_done pulses once, word_count=3. Fetches at 0x0, 0x4, 0x8 on consecutive cycles -> those words return back-to-back with err=0. Fetch at 0xC -> NOP, err=2'b10.
- Fetch at 0x6 -> NOP, err=2'b01. Fetch at 0x40 (above depth) -> NOP, err=2'b10. Fetch at 0x42 -> err=2'b11.
- Load 16 words with load_last never asserted -> auto-terminates after word 16, word_count=16. A 17th load_valid is not accepted (load_ready=0). Fetch at 0x3C -> 16th word.
- Randomised load_valid gaps with 5 words -> only handshaken beats are written; word_count=5 and contents match in order.
- Assert rst_n=0 after 2 of 4 load beats -> outputs return to reset values; after release, fetch at 0x0 -> err=2'b10. A new load succeeds.
